// File: rtl/vga_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_mon_pkg
// Purpose  : Shared constants and types for the VGA frame monitor.
// Revision : 1.0  initial release
// ============================================================================
package vga_mon_pkg;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STAT      = 3'd1;
  localparam logic [2:0] ADDR_WIDTH_LO  = 3'd2;
  localparam logic [2:0] ADDR_WIDTH_HI  = 3'd3;
  localparam logic [2:0] ADDR_HEIGHT_LO = 3'd4;
  localparam logic [2:0] ADDR_HEIGHT_HI = 3'd5;
  localparam logic [2:0] ADDR_CRC_LO    = 3'd6;
  localparam logic [2:0] ADDR_CRC_HI    = 3'd7;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_FREEZE = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_SEL    = 3;

  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_ERR  = 1;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/vga_mon_crc16.sv
`default_nettype none
// ============================================================================
// Module   : vga_mon_crc16
// Purpose  : Combinational CRC-16-CCITT step over one 24-bit pixel, MSB first.
//            Only built when VGA_MON_CRC_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`ifdef VGA_MON_CRC_EN
module vga_mon_crc16
  import vga_mon_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_v;

  always_comb begin
    crc_v = crc_in;
    for (int i = 23; i >= 0; i--) begin
      crc_v = {crc_v[14:0], 1'b0} ^ ((crc_v[15] ^ data_in[i]) ? CRC_POLY : 16'h0000);
    end
    crc_out = crc_v;
  end

endmodule
`endif
`default_nettype wire

// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_monitor
// Purpose  : Passive per-frame width/height/CRC checker with an 8-bit register
//            slave. CRC datapath is built only when VGA_MON_CRC_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int CNT_W           = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_de,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  input  logic       s_cs_n,
  input  logic       s_write,
  input  logic       s_read,
  input  logic [2:0] s_address,
  input  logic [7:0] s_writedata,
  output logic [7:0] s_readdata,
  output logic       irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             hs_q, vs_q, de_q, vs_prev_q, de_prev_q;
  logic             vs_rise, de_fall, measuring, commit, wr_en, rd_en;
  logic [CNT_W-1:0] pix_cnt_q, line_cnt_q, width_ref_q, width_sh_q, height_sh_q;
  logic             err_q, err_sh_q, done_q, irq_q;
  logic [7:0]       fcnt_q, readdata_q, rd_data;
  logic [3:0]       ctrl_q;
  logic [15:0]      width_ext, height_ext, crc_shadow;
  logic             unused_rgb, unused_inputs;

  assign vs_rise   = vs_q & ~vs_prev_q;
  assign de_fall   = de_prev_q & ~de_q;
  assign measuring = (state_q == ST_MEASURE) && !vs_rise;
  assign commit    = (state_q == ST_MEASURE) && vs_rise && !ctrl_q[CTRL_FREEZE];
  assign wr_en     = s_write & ~s_cs_n;
  assign rd_en     = s_read & ~s_cs_n;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A measured frame is committed at the next frame start, then one frame is skipped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_rise) state_d = ST_MEASURE;
      ST_MEASURE: if (vs_rise) state_d = ST_WAIT_VS;
      default:    state_d = ST_IDLE;
    endcase
    if (!ctrl_q[CTRL_EN]) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      de_prev_q   <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      width_ref_q <= '0;
      err_q       <= 1'b0;
      width_sh_q  <= '0;
      height_sh_q <= '0;
      err_sh_q    <= 1'b0;
      fcnt_q      <= 8'h00;
      ctrl_q      <= 4'h0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      readdata_q  <= 8'h00;
    end else begin
      hs_q      <= vga_hs ^ SYNC_ACTIVE_LOW;
      vs_q      <= vga_vs ^ SYNC_ACTIVE_LOW;
      de_q      <= vga_de;
      vs_prev_q <= vs_q;
      de_prev_q <= de_q;

      if (!measuring) begin
        pix_cnt_q   <= '0;
        line_cnt_q  <= '0;
        width_ref_q <= '0;
        err_q       <= 1'b0;
      end else if (de_q) begin
        if (pix_cnt_q == CNT_MAX) err_q <= 1'b1;
        else                      pix_cnt_q <= pix_cnt_q + 1'b1;
      end else if (de_fall) begin
        pix_cnt_q <= '0;
        if (line_cnt_q == '0)              width_ref_q <= pix_cnt_q;
        else if (pix_cnt_q != width_ref_q) err_q <= 1'b1;
        if (line_cnt_q == CNT_MAX) err_q <= 1'b1;
        else                       line_cnt_q <= line_cnt_q + 1'b1;
      end

      if (commit) begin
        width_sh_q  <= width_ref_q;
        height_sh_q <= line_cnt_q;
        err_sh_q    <= err_q;
        fcnt_q      <= fcnt_q + 8'd1;
      end

      if (wr_en && s_address == ADDR_CTRL) ctrl_q <= s_writedata[3:0];

      // Commit has priority over a simultaneous write-1-to-clear.
      if (commit)
        done_q <= 1'b1;
      else if (wr_en && s_address == ADDR_STAT && s_writedata[STAT_DONE])
        done_q <= 1'b0;

      irq_q <= done_q & ctrl_q[CTRL_IRQ_EN];
      if (rd_en) readdata_q <= rd_data;
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [23:0] rgb_q;
  logic [15:0] crc_q, crc_next, crc_sh_q;

  vga_mon_crc16 u_crc16 (
    .crc_in  (crc_q),
    .data_in (rgb_q),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q    <= 24'h000000;
      crc_q    <= CRC_INIT;
      crc_sh_q <= 16'h0000;
    end else begin
      rgb_q <= {vga_r, vga_g, vga_b};
      if (!measuring) crc_q <= CRC_INIT;
      else if (de_q)  crc_q <= crc_next;
      if (commit) crc_sh_q <= crc_q;
    end
  end

  assign crc_shadow = crc_sh_q;
  assign unused_rgb = 1'b0;
`else
  assign crc_shadow = 16'h0000;
  assign unused_rgb = ^{vga_r, vga_g, vga_b};
`endif

  assign width_ext     = 16'(width_sh_q);
  assign height_ext    = 16'(height_sh_q);
  assign unused_inputs = ^{hs_q, s_writedata[7:4], unused_rgb};

  always_comb begin
    rd_data = 8'h00;
    case (s_address)
      ADDR_CTRL:      rd_data = {4'h0, ctrl_q};
      ADDR_STAT:      rd_data = {6'h00, err_sh_q, done_q};
      ADDR_WIDTH_LO:  rd_data = width_ext[7:0];
      ADDR_WIDTH_HI:  rd_data = width_ext[15:8];
      ADDR_HEIGHT_LO: rd_data = height_ext[7:0];
      ADDR_HEIGHT_HI: rd_data = height_ext[15:8];
      ADDR_CRC_LO:    rd_data = crc_shadow[7:0];
      ADDR_CRC_HI:    rd_data = ctrl_q[CTRL_SEL] ? fcnt_q : crc_shadow[15:8];
      default:        rd_data = 8'h00;
    endcase
  end

  assign s_readdata = readdata_q;
  assign irq        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_monitor
// Purpose  : Directed self-checking bench for vga_frame_monitor (small frames).
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_frame_monitor;

  logic       clk = 1'b0;
  logic       reset, vga_hs, vga_vs, vga_de;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       s_cs_n, s_write, s_read;
  logic [2:0] s_address;
  logic [7:0] s_writedata, s_readdata;
  logic       irq;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_crc, meas_crc, crc_red_rd, crc_zero_rd, f3_crc;
  logic [7:0]  exp_fcnt, rd_lo, rd_hi;

  always #5 clk = ~clk;

  vga_frame_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_de      (vga_de),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .s_cs_n      (s_cs_n),
    .s_write     (s_write),
    .s_read      (s_read),
    .s_address   (s_address),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .irq         (irq)
  );

  // Byte-wise reference CRC-16-CCITT, bytes r,g,b in order.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 2; b >= 0; b--) begin
      r = r ^ {d[b*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_exp(input logic [15:0] c);
`ifdef VGA_MON_CRC_EN
    return c;
`else
    return 16'h0000 & c;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_cs_n = 1'b1; s_write = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    s_cs_n = 1'b0; s_read = 1'b1; s_address = a;
    @(negedge clk);
    s_cs_n = 1'b1; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd_reg(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  // Frame: 2 vs lines, 1 back-porch line, n active lines, 1 front-porch line;
  // each line is w active cycles plus 6 blanking cycles. Sync is active low.
  task automatic send_frame(input int w, input int n, input int short_line,
                            input int mode, input int rst_at);
    logic [23:0] px;
    int          lw;
    bit          act;
    exp_crc = 16'hFFFF;
    for (int ln = 0; ln < n + 4; ln++) begin
      act = (ln >= 3) && (ln < n + 3);
      lw  = (act && (ln - 3) == short_line) ? w - 1 : w;
      for (int x = 0; x < w + 6; x++) begin
        @(negedge clk);
        vga_vs = (ln >= 2);
        vga_hs = !((x >= w + 2) && (x < w + 4));
        vga_de = act && (x < lw);
        px = (mode == 0) ? 24'h000000 :
             (mode == 1) ? 24'hFF0000 : {8'(x), 8'(ln), 8'(x * 3)};
        {vga_r, vga_g, vga_b} = vga_de ? px : 24'h000000;
        if (vga_de) exp_crc = crc_model(exp_crc, px);
        if (act && ln == 3 && x == rst_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          vga_de = 1'b0; vga_vs = 1'b1; vga_hs = 1'b1;
          {vga_r, vga_g, vga_b} = 24'h000000;
          return;
        end
      end
    end
  endtask

  // Measured frame followed by a short frame whose start commits it.
  task automatic pair(input int w, input int n, input int short_line, input int mode);
    send_frame(w, n, short_line, mode, -1);
    meas_crc = exp_crc;
    send_frame(2, 1, -1, 0, -1);
    exp_fcnt++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; vga_de = 1'b0;
    vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
    s_cs_n = 1'b1; s_write = 1'b0; s_read = 1'b0; s_address = 3'd0; s_writedata = 8'h00;
    exp_fcnt = 8'h00;
    repeat (4) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_readdata", {8'h00, s_readdata}, 16'h0000);
    check("rst_irq", {15'h0, irq}, 16'h0000);
    for (int a = 0; a < 8; a++) chk_reg($sformatf("rst_reg%0d", a), 3'(a), 8'h00);

    // Red 300x3 frame, irq enabled
    bus_write(3'd0, 8'h05);
    chk_reg("ctrl_rb", 3'd0, 8'h05);
    pair(300, 3, -1, 1);
    chk_reg("red_w_lo", 3'd2, 8'h2C);
    chk_reg("red_w_hi", 3'd3, 8'h01);
    chk_reg("red_h_lo", 3'd4, 8'h03);
    chk_reg("red_h_hi", 3'd5, 8'h00);
    chk_reg("red_stat", 3'd1, 8'h01);
    check("red_irq", {15'h0, irq}, 16'h0001);
    rd_reg(3'd6, rd_lo);
    rd_reg(3'd7, rd_hi);
    crc_red_rd = {rd_hi, rd_lo};
    check("red_crc", crc_red_rd, crc_exp(meas_crc));
    bus_write(3'd0, 8'h0D);
    chk_reg("red_fcnt", 3'd7, exp_fcnt);
    bus_write(3'd0, 8'h05);

    // Write-1-to-clear done drops irq
    bus_write(3'd1, 8'h01);
    chk_reg("clr_stat", 3'd1, 8'h00);
    check("clr_irq", {15'h0, irq}, 16'h0000);

    // Zero-data frame of the same geometry
    pair(300, 3, -1, 0);
    rd_reg(3'd6, rd_lo);
    rd_reg(3'd7, rd_hi);
    crc_zero_rd = {rd_hi, rd_lo};
    check("zero_crc", crc_zero_rd, crc_exp(meas_crc));
`ifdef VGA_MON_CRC_EN
    check("crc_differ", {15'h0, crc_zero_rd != crc_red_rd}, 16'h0001);
`endif
    chk_reg("zero_stat", 3'd1, 8'h01);

    // Short third line sets err; following clean frame clears it
    bus_write(3'd1, 8'h01);
    pair(8, 6, 2, 2);
    chk_reg("short_stat", 3'd1, 8'h03);
    chk_reg("short_w_lo", 3'd2, 8'h08);
    chk_reg("short_h_lo", 3'd4, 8'h06);
    chk_reg("short_crc_lo", 3'd6, crc_exp(meas_crc) & 16'h00FF);
    bus_write(3'd1, 8'h01);
    pair(8, 6, -1, 1);
    chk_reg("clean_stat", 3'd1, 8'h01);

    // Freeze across three frame starts
    bus_write(3'd1, 8'h01);
    bus_write(3'd0, 8'h0B);
    repeat (3) send_frame(5, 2, -1, 1, -1);
    f3_crc = exp_crc;
    chk_reg("frz_w_lo", 3'd2, 8'h08);
    chk_reg("frz_h_lo", 3'd4, 8'h06);
    chk_reg("frz_crc_lo", 3'd6, crc_exp(meas_crc) & 16'h00FF);
    chk_reg("frz_fcnt", 3'd7, exp_fcnt);
    chk_reg("frz_stat", 3'd1, 8'h00);
    bus_write(3'd0, 8'h09);
    send_frame(2, 1, -1, 0, -1);
    exp_fcnt++;
    chk_reg("unfrz_w_lo", 3'd2, 8'h05);
    chk_reg("unfrz_h_lo", 3'd4, 8'h02);
    chk_reg("unfrz_crc_lo", 3'd6, crc_exp(f3_crc) & 16'h00FF);
    chk_reg("unfrz_fcnt", 3'd7, exp_fcnt);
    chk_reg("unfrz_stat", 3'd1, 8'h01);

    // FCNT wrap, with a done-clear write landing on the commit cycle
    while (exp_fcnt != 8'hFF) pair(1, 1, -1, 0);
    chk_reg("fcnt_255", 3'd7, 8'hFF);
    send_frame(3, 2, -1, 1, -1);
    fork
      send_frame(2, 1, -1, 0, -1);
      begin
        @(negedge clk);
        bus_write(3'd1, 8'h01);
      end
    join
    exp_fcnt++;
    chk_reg("fcnt_wrap", 3'd7, exp_fcnt);
    chk_reg("commit_wins", 3'd1, 8'h01);
    chk_reg("wrap_w_lo", 3'd2, 8'h03);

    // Reset mid-line at pixel 300
    send_frame(400, 3, -1, 1, 300);
    check("mrst_readdata", {8'h00, s_readdata}, 16'h0000);
    check("mrst_irq", {15'h0, irq}, 16'h0000);
    for (int a = 0; a < 8; a++) chk_reg($sformatf("mrst_reg%0d", a), 3'(a), 8'h00);
    exp_fcnt = 8'h00;
    bus_write(3'd0, 8'h09);
    send_frame(4, 2, -1, 1, -1);
    f3_crc = exp_crc;
    chk_reg("post1_stat", 3'd1, 8'h00);
    chk_reg("post1_w_lo", 3'd2, 8'h00);
    chk_reg("post1_fcnt", 3'd7, exp_fcnt);
    send_frame(2, 1, -1, 0, -1);
    exp_fcnt++;
    chk_reg("post2_w_lo", 3'd2, 8'h04);
    chk_reg("post2_h_lo", 3'd4, 8'h02);
    chk_reg("post2_crc_lo", 3'd6, crc_exp(f3_crc) & 16'h00FF);
    chk_reg("post2_fcnt", 3'd7, exp_fcnt);
    chk_reg("post2_stat", 3'd1, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
